pipe_ctrl_chain: RTL and testbench

//  Parametrised N-stage valid/allowin/ready_go pipeline-control chain with per-stage payload registers.

---
 rtl/pipe_ctrl_chain_pkg.sv | 24 ++
 rtl/pipe_ctrl_chain_if.sv | 31 +++
 rtl/pipe_ctrl_chain_stage.sv | 47 ++++
 rtl/pipe_ctrl_chain.sv | 72 +++++++
 tb/tb_pipe_ctrl_chain.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_chain_pkg.sv
// Shared definitions for the pipeline-control chain: stage indices, flush-level
// encoding and the flush-level clamp helper.
package pipe_ctrl_chain_pkg;

    // Conventional stage positions for the 4-stage configuration
    localparam int unsigned STAGE_ID   = 0;
    localparam int unsigned STAGE_EX   = 1;
    localparam int unsigned STAGE_MEM  = 2;
    localparam int unsigned STAGE_WB   = 3;

    localparam int unsigned FLUSH_W    = 3;
    localparam int unsigned MAX_STAGES = 8;

    typedef logic [FLUSH_W-1:0] lvl_t;

    // Out-of-range flush levels act as a flush from the last stage
    function automatic lvl_t clamp_lvl(input lvl_t lvl, input int unsigned stages);
        if (32'(lvl) >= stages) begin
            return lvl_t'(stages - 1);
        end
        return lvl;
    endfunction

endpackage

// File: rtl/pipe_ctrl_chain_if.sv
// Handshake/bus bundle of the pipeline-control chain.
//   master : upstream/downstream/stage-logic side (drives in_*, ready_go, flush*, out_ready)
//   slave  : the chain itself (drives in_ready, out_valid, stage_*, retire_cnt)
interface pipe_ctrl_chain_if #(
    parameter int unsigned STAGES = 4,
    parameter int unsigned DW     = 64,
    parameter int unsigned CNT_W  = 32
);
    logic                       in_valid;
    logic                       in_ready;
    logic [DW-1:0]              in_data;
    logic [STAGES-1:0]          ready_go;
    logic                       flush;
    pipe_ctrl_chain_pkg::lvl_t  flush_lvl;
    logic                       out_valid;
    logic                       out_ready;
    logic [STAGES-1:0]          stage_valid;
    logic [STAGES-1:0]          stage_allow;
    logic [STAGES*DW-1:0]       stage_data;
    logic [CNT_W-1:0]           retire_cnt;

    modport master (
        output in_valid, in_data, ready_go, flush, flush_lvl, out_ready,
        input  in_ready, out_valid, stage_valid, stage_allow, stage_data, retire_cnt
    );

    modport slave (
        input  in_valid, in_data, ready_go, flush, flush_lvl, out_ready,
        output in_ready, out_valid, stage_valid, stage_allow, stage_data, retire_cnt
    );
endinterface

// File: rtl/pipe_ctrl_chain_stage.sv
// One pipeline stage: valid bit, payload register and the allowin/to_valid equations.
//   in_valid/in_data : entry offered by the previous stage (or upstream)
//   ready_go         : this stage finished its work
//   allow_next       : allowin of the following stage (or downstream ready)
//   kill_in          : discard the entry arriving this edge
//   kill_hold        : discard the entry held here if it does not move
//   valid/data       : registered stage state
//   allowin          : this stage can take an entry this cycle
//   out_valid        : entry offered to the next stage
module pipe_ctrl_chain_stage #(
    parameter int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          ready_go,
    input  logic          allow_next,
    input  logic          kill_in,
    input  logic          kill_hold,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic          allowin,
    output logic          out_valid
);

    assign allowin   = !valid || (ready_go && allow_next);
    assign out_valid = valid && ready_go;

    // Valid follows the incoming entry when the stage opens, otherwise holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (allowin) begin
                valid <= in_valid && !kill_in;
            end else begin
                valid <= valid && !kill_hold;
            end
            if (allowin && in_valid) begin
                data <= in_data;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// N-stage valid/allowin/ready_go pipeline-control chain with flush and retire counter.
//   clk, reset : clock; asynchronous active-high reset
//   bus        : slave side of pipe_ctrl_chain_if (upstream in_*, downstream out_*,
//                per-stage ready_go, flush/flush_lvl, stage_* observation, retire_cnt)
module pipe_ctrl_chain
    import pipe_ctrl_chain_pkg::*;
#(
    parameter int unsigned STAGES = 4,
    parameter int unsigned DW     = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    pipe_ctrl_chain_if.slave  bus
);

    // Element i is the link into stage i; element STAGES is the downstream link
    logic          allow    [STAGES+1];
    logic          to_valid [STAGES+1];
    logic [DW-1:0] to_data  [STAGES+1];
    logic [STAGES-1:0] valid_q;
    logic [CNT_W-1:0]  retire_q;
    lvl_t              lvl;

    assign lvl           = clamp_lvl(bus.flush_lvl, STAGES);
    assign allow[STAGES] = bus.out_ready;
    assign to_valid[0]   = bus.in_valid;
    assign to_data[0]    = bus.in_data;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic kill_in;
        logic kill_hold;

        // Entries younger than the flushing stage die whether they move or hold;
        // stage L only loses what it would receive from below.
        assign kill_in   = bus.flush && (FLUSH_W'(i) <= lvl);
        assign kill_hold = bus.flush && (FLUSH_W'(i) <  lvl);

        pipe_ctrl_chain_stage #(.DW(DW)) u_stage (
            .clk        (clk),
            .reset      (reset),
            .in_valid   (to_valid[i]),
            .in_data    (to_data[i]),
            .ready_go   (bus.ready_go[i]),
            .allow_next (allow[i+1]),
            .kill_in    (kill_in),
            .kill_hold  (kill_hold),
            .valid      (valid_q[i]),
            .data       (to_data[i+1]),
            .allowin    (allow[i]),
            .out_valid  (to_valid[i+1])
        );

        assign bus.stage_allow[i]          = allow[i];
        assign bus.stage_data[i*DW +: DW]  = to_data[i+1];
    end

    assign bus.stage_valid = valid_q;
    assign bus.in_ready    = allow[0];
    assign bus.out_valid   = to_valid[STAGES];
    assign bus.retire_cnt  = retire_q;

    // Retire counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_q <= '0;
        end else if (to_valid[STAGES] && bus.out_ready) begin
            retire_q <= retire_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed self-checking bench for pipe_ctrl_chain (4 stages, 16-bit payload, 4-bit counter).
module tb_pipe_ctrl_chain;
    import pipe_ctrl_chain_pkg::*;

    localparam int unsigned STAGES = 4;
    localparam int unsigned DW     = 16;
    localparam int unsigned CNT_W  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    pipe_ctrl_chain_if #(.STAGES(STAGES), .DW(DW), .CNT_W(CNT_W)) bus ();

    pipe_ctrl_chain #(.STAGES(STAGES), .DW(DW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [DW-1:0] sdata(input int unsigned i);
        return bus.stage_data[i*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.ready_go  = '1;
        bus.flush     = 1'b0;
        bus.flush_lvl = '0;
        bus.out_ready = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Leaves ID..WB holding base+3, base+2, base+1, base
    task automatic fill4(input int unsigned base);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(base + 32'(k));
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (bus.stage_valid !== 4'b0000) $display("FAIL rst_valid got=%b exp=0000", bus.stage_valid); else pass_cnt++;
        total_cnt++; if (bus.stage_data !== '0) $display("FAIL rst_data got=%h exp=0", bus.stage_data); else pass_cnt++;
        total_cnt++; if (bus.retire_cnt !== 4'd0) $display("FAIL rst_cnt got=%0d exp=0", bus.retire_cnt); else pass_cnt++;
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.stage_allow !== 4'b1111) $display("FAIL rst_allow got=%b exp=1111", bus.stage_allow); else pass_cnt++;
    endtask

    task automatic test_free_flow();
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            bus.in_valid = (c <= 8);
            bus.in_data  = DW'(c);
            tick();
            total_cnt++;
            if (bus.out_valid !== ((c >= 4) && (c <= 11)))
                $display("FAIL flow_out_valid edge=%0d got=%b exp=%b", c, bus.out_valid, ((c >= 4) && (c <= 11)));
            else pass_cnt++;
            if ((c >= 4) && (c <= 11)) begin
                total_cnt++;
                if (sdata(STAGE_WB) !== DW'(c - 3))
                    $display("FAIL flow_wb_data edge=%0d got=%h exp=%h", c, sdata(STAGE_WB), DW'(c - 3));
                else pass_cnt++;
            end
        end
        total_cnt++; if (bus.retire_cnt !== 4'd8) $display("FAIL flow_cnt got=%0d exp=8", bus.retire_cnt); else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [3:0] exp_v [3];
        exp_v[0] = 4'b1011;
        exp_v[1] = 4'b0011;
        exp_v[2] = 4'b0011;
        fill4(8);
        bus.ready_go = 4'b1101;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h000C;
        #1;
        total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.stage_allow !== 4'b1100) $display("FAIL stall_allow got=%b exp=1100", bus.stage_allow); else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            tick();
            total_cnt++;
            if (bus.stage_valid !== exp_v[c]) $display("FAIL stall_valid cyc=%0d got=%b exp=%b", c, bus.stage_valid, exp_v[c]);
            else pass_cnt++;
            total_cnt++;
            if ((sdata(STAGE_EX) !== 16'h000A) || (sdata(STAGE_ID) !== 16'h000B))
                $display("FAIL stall_hold cyc=%0d got=%h/%h exp=000a/000b", c, sdata(STAGE_EX), sdata(STAGE_ID));
            else pass_cnt++;
        end
        total_cnt++; if (bus.retire_cnt !== 4'd2) $display("FAIL stall_cnt_mid got=%0d exp=2", bus.retire_cnt); else pass_cnt++;
        bus.ready_go = '1;
        #1;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL stall_release_ready got=%b exp=1", bus.in_ready); else pass_cnt++;
        tick();
        bus.in_valid = 1'b0;
        total_cnt++; if (bus.stage_valid !== 4'b0111) $display("FAIL stall_resume_valid got=%b exp=0111", bus.stage_valid); else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            tick();
            total_cnt++;
            if (sdata(STAGE_WB) !== DW'(32'hA + 32'(c)))
                $display("FAIL stall_order idx=%0d got=%h exp=%h", c, sdata(STAGE_WB), DW'(32'hA + 32'(c)));
            else pass_cnt++;
        end
        tick();
        total_cnt++; if (bus.stage_valid !== 4'b0000) $display("FAIL stall_drain got=%b exp=0000", bus.stage_valid); else pass_cnt++;
        total_cnt++; if (bus.retire_cnt !== 4'd5) $display("FAIL stall_cnt got=%0d exp=5", bus.retire_cnt); else pass_cnt++;
    endtask

    task automatic test_flush();
        // L=2 under full flow
        fill4(1);
        bus.flush = 1'b1; bus.flush_lvl = 3'd2; bus.in_valid = 1'b1; bus.in_data = 16'h0005;
        #1;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL flush_in_ready got=%b exp=1", bus.in_ready); else pass_cnt++;
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        total_cnt++; if (bus.stage_valid !== 4'b1000) $display("FAIL flush2_valid got=%b exp=1000", bus.stage_valid); else pass_cnt++;
        total_cnt++; if (sdata(STAGE_WB) !== 16'h0002) $display("FAIL flush2_wb got=%h exp=0002", sdata(STAGE_WB)); else pass_cnt++;
        total_cnt++; if (bus.retire_cnt !== 4'd1) $display("FAIL flush2_cnt got=%0d exp=1", bus.retire_cnt); else pass_cnt++;
        // L=0: only the input beat dies
        fill4(1);
        bus.flush = 1'b1; bus.flush_lvl = 3'd0; bus.in_valid = 1'b1; bus.in_data = 16'h0005;
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        total_cnt++; if (bus.stage_valid !== 4'b1110) $display("FAIL flush0_valid got=%b exp=1110", bus.stage_valid); else pass_cnt++;
        total_cnt++; if ((sdata(STAGE_EX) !== 16'h0004) || (sdata(STAGE_WB) !== 16'h0002))
            $display("FAIL flush0_data got=%h/%h exp=0004/0002", sdata(STAGE_EX), sdata(STAGE_WB)); else pass_cnt++;
        // Out-of-range level clamps to the last stage
        fill4(1);
        bus.flush = 1'b1; bus.flush_lvl = 3'd7; bus.in_valid = 1'b1;
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        total_cnt++; if (bus.stage_valid !== 4'b0000) $display("FAIL flush7_valid got=%b exp=0000", bus.stage_valid); else pass_cnt++;
        total_cnt++; if (bus.retire_cnt !== 4'd1) $display("FAIL flush7_cnt got=%0d exp=1", bus.retire_cnt); else pass_cnt++;
        // WB stalled while flushing from MEM: MEM and WB keep their entries
        fill4(1);
        bus.ready_go = 4'b0111; bus.flush = 1'b1; bus.flush_lvl = 3'd2;
        tick();
        bus.flush = 1'b0; bus.ready_go = '1;
        total_cnt++; if (bus.stage_valid !== 4'b1100) $display("FAIL flush_stall_valid got=%b exp=1100", bus.stage_valid); else pass_cnt++;
        total_cnt++; if ((sdata(STAGE_MEM) !== 16'h0002) || (sdata(STAGE_WB) !== 16'h0001))
            $display("FAIL flush_stall_data got=%h/%h exp=0002/0001", sdata(STAGE_MEM), sdata(STAGE_WB)); else pass_cnt++;
        total_cnt++; if (bus.retire_cnt !== 4'd0) $display("FAIL flush_stall_cnt got=%0d exp=0", bus.retire_cnt); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        fill4(1);
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h0005;
        #1;
        total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid got=%b exp=1", bus.out_valid); else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            tick();
            total_cnt++;
            if ((bus.stage_valid !== 4'b1111) || (sdata(STAGE_WB) !== 16'h0001) || (bus.retire_cnt !== 4'd0))
                $display("FAIL bp_hold cyc=%0d got=%b/%h/%0d exp=1111/0001/0", c, bus.stage_valid, sdata(STAGE_WB), bus.retire_cnt);
            else pass_cnt++;
        end
        bus.out_ready = 1'b1; bus.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            total_cnt++;
            if (sdata(STAGE_WB) !== DW'(32'd2 + 32'(c)))
                $display("FAIL bp_order idx=%0d got=%h exp=%h", c, sdata(STAGE_WB), DW'(32'd2 + 32'(c)));
            else pass_cnt++;
        end
        tick();
        total_cnt++; if (bus.retire_cnt !== 4'd4) $display("FAIL bp_cnt got=%0d exp=4", bus.retire_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        fill4(1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        total_cnt++; if (bus.stage_valid !== 4'b0000) $display("FAIL mrst_valid got=%b exp=0000", bus.stage_valid); else pass_cnt++;
        total_cnt++; if (bus.retire_cnt !== 4'd0) $display("FAIL mrst_cnt got=%0d exp=0", bus.retire_cnt); else pass_cnt++;
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 16'h0033;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL mrst_early got=%b exp=0", bus.out_valid); else pass_cnt++;
        tick();
        total_cnt++; if ((bus.out_valid !== 1'b1) || (sdata(STAGE_WB) !== 16'h0033))
            $display("FAIL mrst_first got=%b/%h exp=1/0033", bus.out_valid, sdata(STAGE_WB)); else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 1; c <= 21; c++) begin
            bus.in_valid = (c <= 17);
            bus.in_data  = DW'(c);
            tick();
            if (c == 20) begin
                total_cnt++; if (bus.retire_cnt !== 4'd0) $display("FAIL wrap_16 got=%0d exp=0", bus.retire_cnt); else pass_cnt++;
            end
        end
        total_cnt++; if (bus.retire_cnt !== 4'd1) $display("FAIL wrap_17 got=%0d exp=1", bus.retire_cnt); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_free_flow();
        test_stall();
        test_flush();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
